apb_rr_master: RTL

- Round-robin arbiter and sequencer that shares one APB master port between NREQ simple command requesters.
- Each requester issues single read/write commands on a valid/ready interface and gets a one-cycle response pulse.
- The block drives the APB SETUP/ACCESS phases, honours pready/pslverr, and aborts hung transfers with an optional timeout.
- It sits between internal command sources (CPU shims, DMA, debug) and an APB slave such as the register stub.

---
 rtl/apb_rr_master.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/apb_rr_master.sv
// apb_rr_master: shares one APB master port between NREQ command requesters.
// A round-robin arbiter picks one valid command while idle. The command is then
// driven through the APB SETUP and ACCESS phases. Each accepted command gets a
// one-cycle response pulse, and an optional timeout aborts stalled transfers.

module apb_rr_master #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AWIDTH  = 10,
    parameter int unsigned DSIZE   = 2,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                            pclk,
    input  logic                            preset,
    // Requester command side
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ-1:0]                 req_write,
    input  logic [NREQ*AWIDTH-1:0]          req_addr,
    input  logic [NREQ*(8<<DSIZE)-1:0]      req_wdata,
    input  logic [NREQ*(1<<DSIZE)-1:0]      req_strb,
    input  logic [NREQ*3-1:0]               req_prot,
    // Requester response side
    output logic [NREQ-1:0]                 rsp_valid,
    output logic [(8<<DSIZE)-1:0]           rsp_rdata,
    output logic                            rsp_err,
    // APB master port
    output logic                            psel,
    output logic                            penable,
    output logic                            pwrite,
    output logic [2:0]                      pprot,
    output logic [AWIDTH-1:0]               paddr,
    output logic [(1<<DSIZE)-1:0]           pstrb,
    output logic [(8<<DSIZE)-1:0]           pwdata,
    input  logic [(8<<DSIZE)-1:0]           prdata,
    input  logic                            pready,
    input  logic                            pslverr
);

    localparam int unsigned DBYTES = 1 << DSIZE;
    localparam int unsigned DWIDTH = DBYTES * 8;
    localparam int unsigned GW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       last_grant_q;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    int unsigned         last_grant_int;

    logic [GW-1:0]       win;
    logic                win_found;
    logic                accept;
    logic                finish;
    logic                timed_out;

    logic                cmd_write;
    logic [AWIDTH-1:0]   cmd_addr;
    logic [DWIDTH-1:0]   cmd_wdata;
    logic [DBYTES-1:0]   cmd_strb;
    logic [2:0]          cmd_prot;

    assign last_grant_int = 32'(last_grant_q);

    // Round-robin search: start just after the last grant and wrap around.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!win_found && req_valid[(last_grant_int + k) % NREQ]) begin
                win_found = 1'b1;
                win       = GW'((last_grant_int + k) % NREQ);
            end
        end
    end

    assign accept = (state_q == StIdle) && win_found;

    // Ready is a one-hot grant, only offered while idle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    // Select the winning requester's command fields.
    always_comb begin
        cmd_write = req_write[win];
        cmd_addr  = req_addr[win * AWIDTH +: AWIDTH];
        cmd_wdata = req_wdata[win * DWIDTH +: DWIDTH];
        cmd_strb  = req_strb[win * DBYTES +: DBYTES];
        cmd_prot  = req_prot[win * 3 +: 3];
    end

    // Next-state logic: SETUP always lasts one cycle; ACCESS waits for pready or timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        finish     = 1'b0;
        timed_out  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StSetup;
                    wait_cnt_d = '0;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (pready) begin
                    finish  = 1'b1;
                    state_d = StIdle;
                end else if ((TIMEOUT > 0) && (32'(wait_cnt_q) == TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without pready: abort now.
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, wait counter and arbitration pointer.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            last_grant_q <= GW'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                last_grant_q <= win;
            end
        end
    end

    // APB output registers. Address and data hold their last values between transfers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            pprot   <= '0;
            paddr   <= '0;
            pstrb   <= '0;
            pwdata  <= '0;
        end else if (accept) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            pprot   <= cmd_prot;
            paddr   <= cmd_addr;
            pstrb   <= cmd_write ? cmd_strb : '0;
            pwdata  <= cmd_wdata;
        end else if (state_q == StSetup) begin
            penable <= 1'b1;
        end else if (finish) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    // Response pulse to the requester that owns the current transfer.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (finish) begin
                rsp_valid[last_grant_q] <= 1'b1;
                rsp_rdata               <= (timed_out || pwrite) ? '0 : prdata;
                rsp_err                 <= timed_out | pslverr;
            end
        end
    end

endmodule
